// File: rtl/bus_endpoint_fifo_if.sv
// bus_endpoint_fifo_if: arbiter-, host- and status-facing signals of one bus endpoint
interface bus_endpoint_fifo_if #(parameter int pckg_sz = 16);
  logic pndng, pop, push, tx_wr, tx_full, rx_rd, rx_empty, underflow;
  logic [pckg_sz-1:0] D_pop, D_push, tx_data, rx_data;
  logic [7:0] drop_cnt, misroute_cnt;
  modport master (
    input pndng, D_pop, tx_full, rx_data, rx_empty, drop_cnt, misroute_cnt, underflow,
    output pop, push, D_push, tx_wr, tx_data, rx_rd
  );
  modport slave (
    output pndng, D_pop, tx_full, rx_data, rx_empty, drop_cnt, misroute_cnt, underflow,
    input pop, push, D_push, tx_wr, tx_data, rx_rd
  );
endinterface

// File: rtl/bus_endpoint_fifo.sv
// bus_endpoint_fifo: TX/RX FWFT FIFOs between a bus arbiter port and the device host
module bus_endpoint_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth = 8,
  parameter logic [7:0] id = 8'h00,
  parameter logic [7:0] bcast = 8'hFF
) (
  input logic clk,
  input logic reset,
  bus_endpoint_fifo_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw+1)'(depth);
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [aw:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] drop_q, drop_d, mis_q, mis_d;
  logic under_q, under_d;
  logic tx_full, tx_empty, rx_full, rx_empty, dest_ok, tx_we, tx_re, rx_we, rx_re;
  // full/empty come from registered counts, so a same-cycle read never frees a slot
  always_comb begin
    tx_full = tx_cnt_q == full_cnt;
    tx_empty = tx_cnt_q == '0;
    rx_full = rx_cnt_q == full_cnt;
    rx_empty = rx_cnt_q == '0;
    dest_ok = bus.D_push[pckg_sz-1 -: 8] == id || bus.D_push[pckg_sz-1 -: 8] == bcast;
    tx_we = bus.tx_wr && !tx_full;
    tx_re = bus.pop && !tx_empty;
    rx_we = bus.push && dest_ok && !rx_full;
    rx_re = bus.rx_rd && !rx_empty;
    tx_wp_d = tx_wp_q + aw'(tx_we);
    tx_rp_d = tx_rp_q + aw'(tx_re);
    rx_wp_d = rx_wp_q + aw'(rx_we);
    rx_rp_d = rx_rp_q + aw'(rx_re);
    tx_cnt_d = tx_cnt_q + (aw+1)'(tx_we) - (aw+1)'(tx_re);
    rx_cnt_d = rx_cnt_q + (aw+1)'(rx_we) - (aw+1)'(rx_re);
    drop_d = drop_q + 8'(bus.push && dest_ok && rx_full && drop_q != 8'hFF);
    mis_d = mis_q + 8'(bus.push && !dest_ok && mis_q != 8'hFF);
    under_d = under_q || (bus.pop && tx_empty);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_q <= '0;
      mis_q <= '0;
      under_q <= 1'b0;
    end else begin
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      drop_q <= drop_d;
      mis_q <= mis_d;
      under_q <= under_d;
    end
  end
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_wp_q] <= bus.tx_data;
    if (rx_we) rx_mem[rx_wp_q] <= bus.D_push;
  end
  assign bus.pndng = !tx_empty;
  assign bus.D_pop = tx_empty ? '0 : tx_mem[tx_rp_q];
  assign bus.tx_full = tx_full;
  assign bus.rx_empty = rx_empty;
  assign bus.rx_data = rx_empty ? '0 : rx_mem[rx_rp_q];
  assign bus.drop_cnt = drop_q;
  assign bus.misroute_cnt = mis_q;
  assign bus.underflow = under_q;
endmodule

// File: doc/bus_endpoint_fifo.md
Name: bus_endpoint_fifo

Overview:
- Device-side endpoint for one port of the bus generator/arbiter (bs_gnrtr_n_rbtr); it is the synthesizable counterpart of the bench driver model.
- Holds a TX FIFO that the arbiter drains via pndng/pop/D_pop, and an RX FIFO that the arbiter fills via push/D_push.
- Checks the destination field of received packets.
- One instance per bus port; the device logic sits behind a simple FIFO-style host interface.

Parameters:
- pckg_sz, 16, packet width in bits; [pckg_sz-1:pckg_sz-8] = destination ID, rest = payload.
- depth, 8, entries per FIFO (TX and RX each); power of two, >=2.
- id, 0, this endpoint's 8-bit bus ID.
- bcast, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- pndng  out  1  TX FIFO non-empty, to arbiter.
- D_pop  out  pckg_sz  TX head word (first-word fall-through).
- pop  in  1  arbiter consumes D_pop this cycle.
- push  in  1  arbiter delivers D_push this cycle.
- D_push  in  pckg_sz  incoming packet.
- tx_wr  in  1  host writes tx_data.
- tx_data  in  pckg_sz  host packet to send.
- tx_full  out  1  TX FIFO full.
- rx_rd  in  1  host consumes rx_data.
- rx_data  out  pckg_sz  RX head word (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- drop_cnt  out  8  saturating count of RX packets dropped because RX was full.
- misroute_cnt  out  8  saturating count of RX packets dropped for a wrong destination.
- underflow  out  1  sticky; pop seen while TX empty.

Behaviour:
- Reset (reset=0, async):
  - Both FIFOs are emptied and pointers/counts cleared.
  - pndng=0, tx_full=0, rx_empty=1, drop_cnt=0, misroute_cnt=0, underflow=0.
  - D_pop and rx_data are 0 while empty.
  - Reset mid-transfer discards all contents; the first edge after release behaves as after power-up.
- FIFO structure: each FIFO is a circular buffer with rd/wr pointers (log2(depth) bits, natural wrap) plus a count of log2(depth)+1 bits.
  - full = (count==depth); empty = (count==0).
- TX write:
  - tx_wr with tx_full=0 stores tx_data at wr_ptr.
  - tx_wr with tx_full=1 is ignored, with no state change.
- TX read:
  - pndng = !empty, registered-state derived, no combinational path from pop.
  - D_pop shows the head entry combinationally from storage.
  - pop with pndng=1 advances rd_ptr at the edge; the next entry is visible the following cycle (0 if the FIFO becomes empty).
  - pop with pndng=0 is ignored and sets underflow (cleared only by reset).
- Simultaneous tx_wr and pop:
  - Both take effect; count unchanged.
  - When full, tx_wr is still rejected (full is evaluated before the pop).
  - When empty, pop is an underflow and the write is accepted.
- RX accept rule: push=1 with D_push[pckg_sz-1:pckg_sz-8] equal to id or bcast, and RX not full, stores D_push.
- RX drop rules:
  - Destination mismatch: misroute_cnt increments; the mismatch check takes priority over the full check.
  - Matching destination while RX full: drop_cnt increments.
  - Both counters saturate at 255.
- RX read:
  - rx_data is the FWFT head; rx_rd with rx_empty=0 advances.
  - rx_rd while empty is ignored.
  - Simultaneous push and rx_rd on a full RX: the push is dropped (full evaluated before the read).
- Latency: 1 cycle from accepted write to visibility on the other side (pndng/D_pop or rx_empty/rx_data).
- Stored words are never modified; the packet is passed whole, including the ID field.

Test Plan:
- Reset then idle:
  - Required: pndng=0, D_pop=0, tx_full=0, rx_empty=1, counters 0.
  - Assert reset=0 mid-operation with 3 TX words queued -> pndng=0 immediately (async).
- TX ordering:
  - Write 16'h0101, 16'h0202, 16'h0303 (id=0); pndng=1 one cycle after the first write.
  - Pop on 3 consecutive cycles -> D_pop sequence 0101, 0202, 0303, then pndng=0.
- TX full/wrap:
  - Write 8 words -> tx_full=1; a 9th write is ignored.
  - 4 pops, 4 writes -> pointers wrap and output order is preserved.
  - A pop on empty -> underflow=1 and stays 1.
- RX filtering:
  - With id=8'h02: push 16'h02AA -> stored; 16'hFF55 -> stored; 16'h0377 -> dropped, misroute_cnt=1.
  - rx_data order: 02AA then FF55.
- RX overflow:
  - Fill RX with 8 matching packets, push 3 more -> drop_cnt=3.
  - Push with simultaneous rx_rd while full -> the push is dropped, drop_cnt=4.
  - 300 overflow pushes -> drop_cnt saturates at 255.
- Simultaneous ops:
  - tx_wr+pop each cycle with 1 entry queued for 10 cycles -> count stays 1 and D_pop tracks the written data with 1-cycle delay.
